stream_adder: RTL and testbench

Parametrised, pipelined, multi-lane unsigned add/subtract unit with valid/ready handshaking. It is the generalised successor of the team's 8-bit `io_A + io_B -> io_X` adder: width, lane count and pipeline depth are configurable, and it adds a per-beat operation select (wrap or saturate, add or sub), per-lane overflow flags, backpressure and a beat counter. It sits between a stimulus source and a checker/sink in the transaction-level simulation flow.

---
 rtl/stream_adder_pkg.sv | 30 +++
 rtl/stream_adder_lane.sv | 53 +++++
 rtl/stream_adder.sv | 122 ++++++++++++
 tb/tb_stream_adder.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_adder_pkg.sv
// Shared types and helpers for the stream_adder block: the per-beat operation
// encoding and a slice helper for lane-packed operand buses.
package stream_adder_pkg;

    // Per-beat operation select, carried alongside the operands.
    typedef enum logic [1:0] {
        ADD_WRAP = 2'd0,
        ADD_SAT  = 2'd1,
        SUB_WRAP = 2'd2,
        SUB_SAT  = 2'd3
    } op_t;

    // Upper bounds of the supported configuration range.
    localparam int MAX_WIDTH = 32;
    localparam int MAX_LANES = 16;
    localparam int MAX_BUS_W = MAX_WIDTH * MAX_LANES;

    // Extract lane idx (width bits wide) from a packed bus zero-extended to
    // MAX_BUS_W; the result is right-aligned and zero-filled above width.
    function automatic logic [MAX_WIDTH-1:0] lane_slice(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          idx,
        input int unsigned          width
    );
        logic [MAX_WIDTH-1:0] mask;
        mask = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
        return MAX_WIDTH'(bus >> (idx * width)) & mask;
    endfunction

endpackage

// File: rtl/stream_adder_lane.sv
// One lane of the stream adder: unsigned WIDTH-bit add or subtract with
// optional saturation. The ovf flag is the raw carry/borrow regardless of
// whether the result was saturated.
module stream_adder_lane
    import stream_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] x,
    output logic             ovf
);

    // One extra bit holds the carry (add) or the borrow (sub): for the
    // difference, bit WIDTH is set exactly when a < b.
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // Select the wrapped or clamped result for the requested operation.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        x   = '0;
        ovf = 1'b0;
        case (op)
            ADD_WRAP: begin
                x   = sum[WIDTH-1:0];
                ovf = sum[WIDTH];
            end
            ADD_SAT: begin
                x   = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
                ovf = sum[WIDTH];
            end
            SUB_WRAP: begin
                x   = diff[WIDTH-1:0];
                ovf = diff[WIDTH];
            end
            SUB_SAT: begin
                x   = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
                ovf = diff[WIDTH];
            end
            default: begin
                x   = '0;
                ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/stream_adder.sv
// Pipelined multi-lane add/subtract unit with valid/ready handshaking.
// The lane arithmetic is registered into stage 0 of a STAGES-deep register
// chain; all stages share one enable, so the whole pipe advances or holds
// together. Bubbles travel through the pipe and are never collapsed.
module stream_adder
    import stream_adder_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LANES   = 2,
    parameter int STAGES  = 2,
    parameter int COUNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     io_in_valid,
    output logic                     io_in_ready,
    input  logic [LANES*WIDTH-1:0]   io_A,
    input  logic [LANES*WIDTH-1:0]   io_B,
    input  logic [1:0]               io_op,
    output logic                     io_out_valid,
    input  logic                     io_out_ready,
    output logic [LANES*WIDTH-1:0]   io_X,
    output logic [LANES-1:0]         io_ovf,
    output logic [COUNT_W-1:0]       io_count
);

    localparam int BUS_W = LANES * WIDTH;

    op_t              op_in;
    logic [BUS_W-1:0] lane_x;
    logic [LANES-1:0] lane_ovf;

    assign op_in = op_t'(io_op);

    // Independent lanes; no carry crosses a lane boundary.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [WIDTH-1:0] a_l;
        logic [WIDTH-1:0] b_l;

        assign a_l = WIDTH'(lane_slice(MAX_BUS_W'(io_A), gi, WIDTH));
        assign b_l = WIDTH'(lane_slice(MAX_BUS_W'(io_B), gi, WIDTH));

        stream_adder_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .a   (a_l),
            .b   (b_l),
            .op  (op_in),
            .x   (lane_x[gi*WIDTH +: WIDTH]),
            .ovf (lane_ovf[gi])
        );
    end

    // Pipeline state: index 0 is the arithmetic stage, STAGES-1 the output.
    logic [STAGES-1:0]  vld_q;
    logic [STAGES-1:0]  vld_d;
    logic [BUS_W-1:0]   x_q   [STAGES];
    logic [BUS_W-1:0]   x_d   [STAGES];
    logic [LANES-1:0]   ovf_q [STAGES];
    logic [LANES-1:0]   ovf_d [STAGES];
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    logic advance;
    logic accept;

    // A stalled output blocks the whole pipe; an empty output slot never does.
    assign io_out_valid = vld_q[STAGES-1];
    assign io_in_ready  = io_out_ready || !io_out_valid;
    assign advance      = io_in_ready;
    assign accept       = io_in_valid && advance;

    assign io_X     = x_q[STAGES-1];
    assign io_ovf   = ovf_q[STAGES-1];
    assign io_count = count_q;

    // Next-state for the stage chain and the accepted-beat counter.
    always_comb begin
        vld_d   = vld_q;
        x_d     = x_q;
        ovf_d   = ovf_q;
        count_d = count_q;

        if (advance) begin
            // Bubbles carry zero data so io_X/io_ovf read 0 when not valid.
            vld_d[0] = io_in_valid;
            x_d[0]   = io_in_valid ? lane_x   : '0;
            ovf_d[0] = io_in_valid ? lane_ovf : '0;
            for (int s = 1; s < STAGES; s++) begin
                vld_d[s] = vld_q[s-1];
                x_d[s]   = x_q[s-1];
                ovf_d[s] = ovf_q[s-1];
            end
        end

        if (accept) begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    // Register the chain; reset discards every in-flight beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q   <= '0;
            count_q <= '0;
            // NOTE: data stages are reset too (not just valids) so io_X and
            // io_ovf read 0 straight out of reset rather than leftover data.
            for (int s = 0; s < STAGES; s++) begin
                x_q[s]   <= '0;
                ovf_q[s] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates so every stage samples the old value
            // of its predecessor, which is what makes this a shift chain.
            vld_q   <= vld_d;
            x_q     <= x_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_stream_adder.sv
// Self-checking bench for stream_adder (WIDTH=8, LANES=2, STAGES=2, COUNT_W=4).
// A per-cycle monitor keeps a queue of expected results computed from plain
// integer arithmetic and checks every transferred output beat, the counter,
// the ready rule, idle zeroing and output stability under backpressure.
module tb_stream_adder;

    localparam int W  = 8;
    localparam int L  = 2;
    localparam int S  = 2;
    localparam int CW = 4;
    localparam int BW = W * L;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [BW-1:0] a_in      = '0;
    logic [BW-1:0] b_in      = '0;
    logic [1:0]    op_in     = 2'd0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [BW-1:0] x_out;
    logic [L-1:0]  ovf_out;
    logic [CW-1:0] count_out;

    always #5 clk = ~clk;

    stream_adder #(
        .WIDTH   (W),
        .LANES   (L),
        .STAGES  (S),
        .COUNT_W (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .io_in_valid  (in_valid),
        .io_in_ready  (in_ready),
        .io_A         (a_in),
        .io_B         (b_in),
        .io_op        (op_in),
        .io_out_valid (out_valid),
        .io_out_ready (out_ready),
        .io_X         (x_out),
        .io_ovf       (ovf_out),
        .io_count     (count_out)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: {ovf[L-1:0], X[BW-1:0]} from the lane rules in integers.
    function automatic logic [L+BW-1:0] model(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                              input logic [1:0] o);
        logic [L+BW-1:0] r;
        r = '0;
        for (int l = 0; l < L; l++) begin
            int av;
            int bv;
            int res;
            bit ov;
            av = int'(a[l*W +: W]);
            bv = int'(b[l*W +: W]);
            case (o)
                2'd0: begin res = av + bv; ov = (res > 255); res = res % 256; end
                2'd1: begin res = av + bv; ov = (res > 255); if (ov) res = 255; end
                2'd2: begin ov = (av < bv); res = (av - bv + 256) % 256; end
                default: begin ov = (av < bv); res = ov ? 0 : av - bv; end
            endcase
            r[l*W +: W] = 8'(res);
            r[BW + l]   = ov;
        end
        return r;
    endfunction

    // Per-cycle monitor, sampled 1 time unit after the falling edge while all
    // inputs are stable until the next rising edge.
    logic [L+BW-1:0] exp_q[$];
    int              acc_cnt   = 0;
    bit              prev_hold = 0;
    logic [BW-1:0]   prev_x;
    logic [L-1:0]    prev_ovf;

    always begin
        @(negedge clk);
        #1;
        if (!reset) begin
            exp_q.delete();
            acc_cnt   = 0;
            prev_hold = 0;
            check("reset out_valid", out_valid, 0);
            check("reset count", count_out, 0);
            check("reset in_ready", in_ready, 1);
        end else begin
            logic [L+BW-1:0] e;
            check("count", count_out, acc_cnt % 16);
            check("in_ready rule", in_ready, out_ready || !out_valid);
            if (!out_valid) check("idle X/ovf zero", {ovf_out, x_out}, 0);
            if (prev_hold) begin
                check("held valid", out_valid, 1);
                check("held X", x_out, prev_x);
                check("held ovf", ovf_out, prev_ovf);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat X", x_out, e[BW-1:0]);
                    check("beat ovf", ovf_out, e[L+BW-1:BW]);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a_in, b_in, op_in));
                acc_cnt++;
            end
            prev_hold = out_valid && !out_ready;
            prev_x    = x_out;
            prev_ovf  = ovf_out;
        end
    end

    // Present a beat from a falling edge and hold it until accepted; returns
    // at the falling edge after the accepting rising edge, in_valid still 1.
    task automatic send(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [1:0] o);
        bit ok;
        ok       = 0;
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        op_in    = o;
        for (int n = 0; n < 100 && !ok; n++) begin
            #1;
            ok = in_ready;
            @(negedge clk);
        end
        if (!ok) check("send timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Single beat with literal expectations and an exact latency check.
    task automatic directed(input string name, input logic [BW-1:0] a, input logic [BW-1:0] b,
                            input logic [1:0] o, input logic [BW-1:0] ex, input logic [L-1:0] eo);
        send(a, b, o);
        in_valid = 1'b0;
        #1;
        check({name, " not yet valid"}, out_valid, 0);
        @(negedge clk);
        #1;
        check({name, " valid"}, out_valid, 1);
        check({name, " X"}, x_out, ex);
        check({name, " ovf"}, ovf_out, eo);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    bit done;

    initial begin
        // Power-on reset: outputs idle.
        repeat (2) @(negedge clk);
        #1;
        check("por X", x_out, 0);
        check("por ovf", ovf_out, 0);
        check("por in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Pin the reference model with hand-worked results (lane 0 is low byte).
        check("model add_wrap", model(16'h05C8, 16'h0364, 2'd0), {2'b01, 16'h082C});
        check("model add_sat",  model(16'h05C8, 16'h0364, 2'd1), {2'b01, 16'h08FF});
        check("model sub_sat",  model(16'h0903, 16'h0405, 2'd3), {2'b01, 16'h0500});
        check("model sub_wrap", model(16'h0903, 16'h0405, 2'd2), {2'b01, 16'h05FE});

        // Lane 0: 200+100, 3-5 ; lane 1: 5+3, 9-4.
        directed("add_wrap", 16'h05C8, 16'h0364, 2'd0, 16'h082C, 2'b01);
        directed("add_sat",  16'h05C8, 16'h0364, 2'd1, 16'h08FF, 2'b01);
        directed("sub_sat",  16'h0903, 16'h0405, 2'd3, 16'h0500, 2'b01);
        directed("sub_wrap", 16'h0903, 16'h0405, 2'd2, 16'h05FE, 2'b01);

        // Back-to-back: 20 beats A=B=i, results 2i in order with no gaps.
        fork
            begin
                for (int i = 0; i < 20; i++) send({8'(i), 8'(i)}, {8'(i), 8'(i)}, 2'd0);
                in_valid = 1'b0;
            end
            begin
                bit seen;
                seen = 0;
                for (int n = 0; n < 10 && !seen; n++) begin
                    @(negedge clk);
                    #1;
                    seen = out_valid;
                end
                if (!seen) begin
                    check("b2b first output", 0, 1);
                end else begin
                    for (int k = 0; k < 20; k++) begin
                        check("b2b valid", out_valid, 1);
                        check("b2b X", x_out, {8'(2 * k), 8'(2 * k)});
                        if (k < 19) begin
                            @(negedge clk);
                            #1;
                        end
                    end
                end
            end
        join
        @(negedge clk);
        repeat (3) @(negedge clk);

        // Backpressure: stall the sink for 5 cycles mid-stream.
        fork
            begin
                for (int i = 0; i < 12; i++) send(16'($urandom), 16'($urandom), 2'($urandom_range(3)));
                in_valid = 1'b0;
            end
            begin
                logic [BW-1:0] hx;
                repeat (6) @(negedge clk);
                out_ready = 1'b0;
                #1;
                check("bp out_valid", out_valid, 1);
                check("bp in_ready falls", in_ready, 0);
                hx = x_out;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    if (c < 4) begin
                        #1;
                        check("bp X holds", x_out, hx);
                    end
                end
                out_ready = 1'b1;
            end
        join
        @(negedge clk);
        repeat (5) @(negedge clk);
        check("bp drained", exp_q.size(), 0);

        // Random traffic with random gaps and random sink readiness.
        done = 0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(3) == 0) begin
                        in_valid = 1'b0;
                        @(negedge clk);
                    end
                    send(16'($urandom), 16'($urandom), 2'($urandom_range(3)));
                end
                in_valid = 1'b0;
                done     = 1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(9) < 7);
                end
                out_ready = 1'b1;
            end
        join
        @(negedge clk);
        repeat (8) @(negedge clk);
        check("random drained", exp_q.size(), 0);

        // Counter wraps at 16: 17 accepted beats leave it at 1.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 17; i++) send({8'(i), 8'(i)}, 16'h0000, 2'd0);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("count wrap", count_out, 1);
        @(negedge clk);

        // Reset with two beats in flight: immediate clear, nothing emerges later.
        send(16'h1111, 16'h2222, 2'd0);
        send(16'h3333, 16'h4444, 2'd1);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("mid reset out_valid", out_valid, 0);
        check("mid reset X", x_out, 0);
        check("mid reset count", count_out, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            check("no stale beat", out_valid, 0);
        end
        @(negedge clk);
        check("final drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
